// File: rtl/run_trace_ctrl.sv
// -----------------------------------------------------------------------------
// run_trace_ctrl
//
// Run controller and write-back trace buffer for the MIPS pipeline datapath.
// After an accepted start it holds the datapath clock-enable low for WARMUP
// cycles, so the pipeline flushes its reset state. It then raises ce for the
// latched number of cycles and ends in DONE. During RUN every qualified
// write-back is captured as a {pc, data} pair into a FIFO. In DONE the trace is
// drained through a one-cycle-latency read port.
//
// Ports
//   rt_clk            clock, rising edge
//   rt_rst            synchronous reset, active high
//   rt_i_start        start pulse, honoured in IDLE or DONE only
//   rt_i_cycles       run length, latched on an accepted start
//   rt_o_ce           registered clock-enable to the datapath
//   rt_i_pc           PC from the datapath
//   rt_i_wb_data      write-back data from the datapath
//   rt_i_wb_valid     write-back qualifier
//   rt_o_busy         high in WARMUP and RUN
//   rt_o_done         high in DONE
//   rt_o_cycle_cnt    RUN cycles elapsed, saturating at the limit
//   rt_o_capture_cnt  FIFO occupancy, 0..DEPTH
//   rt_o_overflow     sticky: a capture was dropped on a full FIFO
//   rt_i_rd_en        pop request (DONE only)
//   rt_o_rd_valid     one-cycle pulse qualifying rd_pc / rd_data
//   rt_o_rd_pc        popped PC, holds when rd_valid is low
//   rt_o_rd_data      popped write-back data, holds when rd_valid is low
//   rt_o_empty        FIFO empty
// -----------------------------------------------------------------------------
module run_trace_ctrl #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CW       = 16,
  parameter int unsigned WARMUP   = 2
) (
  input  logic                       rt_clk,
  input  logic                       rt_rst,
  input  logic                       rt_i_start,
  input  logic [CW-1:0]              rt_i_cycles,
  output logic                       rt_o_ce,
  input  logic [PC_WIDTH-1:0]        rt_i_pc,
  input  logic [DWIDTH-1:0]          rt_i_wb_data,
  input  logic                       rt_i_wb_valid,
  output logic                       rt_o_busy,
  output logic                       rt_o_done,
  output logic [CW-1:0]              rt_o_cycle_cnt,
  output logic [$clog2(DEPTH):0]     rt_o_capture_cnt,
  output logic                       rt_o_overflow,
  input  logic                       rt_i_rd_en,
  output logic                       rt_o_rd_valid,
  output logic [PC_WIDTH-1:0]        rt_o_rd_pc,
  output logic [DWIDTH-1:0]          rt_o_rd_data,
  output logic                       rt_o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  // Warm-up counter spans 0..WARMUP-1.
  localparam int unsigned WW = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_ce;
  logic                w_ce_nxt;
  logic [CW-1:0]       r_limit;
  logic [CW-1:0]       r_cycle_cnt;
  logic [WW-1:0]       r_warm_cnt;

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [OW-1:0]       r_count;
  logic                r_overflow;

  logic                r_rd_valid;
  logic [PC_WIDTH-1:0] r_rd_pc;
  logic [DWIDTH-1:0]   r_rd_data;

  logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [DWIDTH-1:0]   r_mem_data [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic w_idle_or_done;
  logic w_start_acc;
  logic w_full;
  logic w_empty;
  logic w_capture;
  logic w_wr_en;
  logic w_drop;
  logic w_rd_en;
  logic w_warm_last;
  logic w_run_last;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_acc    = rt_i_start && w_idle_or_done;
  assign w_full         = (r_count == OCC_FULL);
  assign w_empty        = (r_count == '0);
  assign w_capture      = (r_state == S_RUN) && rt_i_wb_valid;
  assign w_wr_en        = w_capture && !w_full;
  assign w_drop         = w_capture && w_full;
  // A start in DONE takes priority over a pop in the same cycle.
  assign w_rd_en        = (r_state == S_DONE) && rt_i_rd_en && !w_empty && !w_start_acc;
  assign w_warm_last    = (r_warm_cnt == WARM_LAST);
  // Last RUN cycle: this edge brings cycle_cnt up to the limit.
  assign w_run_last     = (r_state == S_RUN) && ((r_cycle_cnt + CW'(1)) == r_limit);

  // ---------------------------------------------------------------------------
  // Next state; ce is registered alongside the state so it is high exactly in RUN
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_acc) begin
          if (rt_i_cycles == '0) begin
            w_state_nxt = S_DONE;
          end else if (WARMUP == 0) begin
            w_state_nxt = S_RUN;
            w_ce_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_WARMUP;
          end
        end
      end
      S_WARMUP: begin
        if (w_warm_last) begin
          w_state_nxt = S_RUN;
          w_ce_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_run_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_ce_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rt_clk) begin
    if (rt_rst) begin
      r_state     <= S_IDLE;
      r_ce        <= 1'b0;
      r_limit     <= '0;
      r_cycle_cnt <= '0;
      r_warm_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= w_ce_nxt;
      if (w_start_acc) begin
        r_limit     <= rt_i_cycles;
        r_cycle_cnt <= '0;
        r_warm_cnt  <= '0;
      end else begin
        if (r_state == S_WARMUP) begin
          r_warm_cnt <= r_warm_cnt + WW'(1);
        end
        if ((r_state == S_RUN) && (r_cycle_cnt != r_limit)) begin
          r_cycle_cnt <= r_cycle_cnt + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and sticky overflow
  // Writes happen only in RUN and pops only in DONE, so they never coincide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge rt_clk) begin
    if (rt_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_acc) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + OW'(1);
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - OW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge rt_clk) begin
    if (w_wr_en) begin
      r_mem_pc[r_wr_ptr]   <= rt_i_pc;
      r_mem_data[r_wr_ptr] <= rt_i_wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: data registers hold their value between pops
  // ---------------------------------------------------------------------------
  always_ff @(posedge rt_clk) begin
    if (rt_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_pc   <= r_mem_pc[r_rd_ptr];
        r_rd_data <= r_mem_data[r_rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rt_o_ce          = r_ce;
  assign rt_o_busy        = (r_state == S_WARMUP) || (r_state == S_RUN);
  assign rt_o_done        = (r_state == S_DONE);
  assign rt_o_cycle_cnt   = r_cycle_cnt;
  assign rt_o_capture_cnt = r_count;
  assign rt_o_overflow    = r_overflow;
  assign rt_o_rd_valid    = r_rd_valid;
  assign rt_o_rd_pc       = r_rd_pc;
  assign rt_o_rd_data     = r_rd_data;
  assign rt_o_empty       = w_empty;

endmodule

// File: tb/tb_run_trace_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_trace_ctrl
//
// Randomized bench for run_trace_ctrl (DEPTH=4 so overflow is exercised often).
// The reference model tracks time since the accepted start as a plain cycle
// index and derives ce/busy/done/cycle_cnt arithmetically from the warm-up
// length and run length; captured pairs live in a queue.
// -----------------------------------------------------------------------------
module tb_run_trace_ctrl;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = 16;
  localparam int unsigned WARMUP   = 2;

  logic                   rt_clk = 1'b0;
  logic                   rt_rst;
  logic                   rt_i_start;
  logic [CW-1:0]          rt_i_cycles;
  logic                   rt_o_ce;
  logic [PC_WIDTH-1:0]    rt_i_pc;
  logic [DWIDTH-1:0]      rt_i_wb_data;
  logic                   rt_i_wb_valid;
  logic                   rt_o_busy;
  logic                   rt_o_done;
  logic [CW-1:0]          rt_o_cycle_cnt;
  logic [$clog2(DEPTH):0] rt_o_capture_cnt;
  logic                   rt_o_overflow;
  logic                   rt_i_rd_en;
  logic                   rt_o_rd_valid;
  logic [PC_WIDTH-1:0]    rt_o_rd_pc;
  logic [DWIDTH-1:0]      rt_o_rd_data;
  logic                   rt_o_empty;

  run_trace_ctrl #(
    .PC_WIDTH (PC_WIDTH),
    .DWIDTH   (DWIDTH),
    .DEPTH    (DEPTH),
    .CW       (CW),
    .WARMUP   (WARMUP)
  ) u_dut (
    .rt_clk           (rt_clk),
    .rt_rst           (rt_rst),
    .rt_i_start       (rt_i_start),
    .rt_i_cycles      (rt_i_cycles),
    .rt_o_ce          (rt_o_ce),
    .rt_i_pc          (rt_i_pc),
    .rt_i_wb_data     (rt_i_wb_data),
    .rt_i_wb_valid    (rt_i_wb_valid),
    .rt_o_busy        (rt_o_busy),
    .rt_o_done        (rt_o_done),
    .rt_o_cycle_cnt   (rt_o_cycle_cnt),
    .rt_o_capture_cnt (rt_o_capture_cnt),
    .rt_o_overflow    (rt_o_overflow),
    .rt_i_rd_en       (rt_i_rd_en),
    .rt_o_rd_valid    (rt_o_rd_valid),
    .rt_o_rd_pc       (rt_o_rd_pc),
    .rt_o_rd_data     (rt_o_rd_data),
    .rt_o_empty       (rt_o_empty)
  );

  always #5 rt_clk = ~rt_clk;

  // Reference model state
  logic [63:0]         m_q [$];
  bit                  m_ovf;
  logic [PC_WIDTH-1:0] m_last_pc;
  logic [DWIDTH-1:0]   m_last_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge rt_clk);
    #1;
  endtask

  task automatic check_fifo_view();
    check_eq("capture_cnt", 64'(rt_o_capture_cnt), 64'(m_q.size()));
    check_eq("overflow", 64'(rt_o_overflow), 64'(m_ovf));
    check_eq("empty", 64'(rt_o_empty), 64'(m_q.size() == 0));
  endtask

  task automatic check_reset();
    check_eq("rst_ce", 64'(rt_o_ce), 64'd0);
    check_eq("rst_busy", 64'(rt_o_busy), 64'd0);
    check_eq("rst_done", 64'(rt_o_done), 64'd0);
    check_eq("rst_cycle_cnt", 64'(rt_o_cycle_cnt), 64'd0);
    check_eq("rst_capture_cnt", 64'(rt_o_capture_cnt), 64'd0);
    check_eq("rst_overflow", 64'(rt_o_overflow), 64'd0);
    check_eq("rst_rd_valid", 64'(rt_o_rd_valid), 64'd0);
    check_eq("rst_rd_pc", 64'(rt_o_rd_pc), 64'd0);
    check_eq("rst_rd_data", 64'(rt_o_rd_data), 64'd0);
    check_eq("rst_empty", 64'(rt_o_empty), 64'd1);
  endtask

  // k = edges since the accepted start edge (k=0 right after it).
  task automatic check_phase(input int k, input int n);
    int  w;
    bit  in_run;
    bit  fin;
    int  cc;
    w      = (n == 0) ? 0 : int'(WARMUP);
    in_run = (k >= w) && (k < w + n);
    fin    = (k >= w + n);
    cc     = (k < w) ? 0 : ((k - w > n) ? n : k - w);
    check_eq("ce", 64'(rt_o_ce), 64'(in_run));
    check_eq("busy", 64'(rt_o_busy), 64'(!fin));
    check_eq("done", 64'(rt_o_done), 64'(fin));
    check_eq("cycle_cnt", 64'(rt_o_cycle_cnt), 64'(cc));
    check_eq("rd_valid_run", 64'(rt_o_rd_valid), 64'd0);
    check_fifo_view();
  endtask

  task automatic start_run(input int n, input bit with_rd);
    rt_i_start    = 1'b1;
    rt_i_cycles   = CW'(n);
    rt_i_rd_en    = with_rd;
    rt_i_wb_valid = 1'($urandom_range(0, 1));
    step();
    rt_i_start = 1'b0;
    rt_i_rd_en = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    check_eq("start_no_pop", 64'(rt_o_rd_valid), 64'd0);
    check_phase(0, n);
  endtask

  // Drive the run to completion. all_valid forces wb_valid high every cycle.
  // rst_idx >= 0 asserts reset during that (0-based) RUN cycle.
  task automatic run_body(input int n, input int rst_idx, input bit all_valid);
    int  w;
    bit  is_run;
    bit  stop;
    w    = (n == 0) ? 0 : int'(WARMUP);
    stop = 1'b0;
    for (int k = 0; k < w + n && !stop; k++) begin
      is_run        = (k >= w);
      rt_i_pc       = $urandom;
      rt_i_wb_data  = $urandom;
      rt_i_wb_valid = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      rt_i_rd_en    = 1'($urandom_range(0, 1));
      // Starts while busy must be ignored.
      rt_i_start    = ($urandom_range(0, 3) == 0);
      rt_i_cycles   = CW'($urandom_range(0, 7));
      if (rst_idx >= 0 && is_run && (k - w == rst_idx)) begin
        rt_rst = 1'b1;
        step();
        rt_rst      = 1'b0;
        m_q.delete();
        m_ovf       = 1'b0;
        m_last_pc   = '0;
        m_last_data = '0;
        check_reset();
        stop = 1'b1;
      end else begin
        step();
        if (is_run && rt_i_wb_valid) begin
          if (m_q.size() < DEPTH) m_q.push_back({rt_i_pc, rt_i_wb_data});
          else m_ovf = 1'b1;
        end
        check_phase(k + 1, n);
      end
    end
    rt_i_start    = 1'b0;
    rt_i_rd_en    = 1'b0;
    rt_i_wb_valid = 1'b0;
  endtask

  task automatic drain();
    bit pop;
    for (int i = 0; i < 12; i++) begin
      rt_i_rd_en    = ($urandom_range(0, 3) != 0);
      rt_i_wb_valid = 1'($urandom_range(0, 1));
      rt_i_pc       = $urandom;
      rt_i_wb_data  = $urandom;
      pop           = rt_i_rd_en && (m_q.size() > 0);
      step();
      if (pop) {m_last_pc, m_last_data} = m_q.pop_front();
      check_eq("rd_valid", 64'(rt_o_rd_valid), 64'(pop));
      check_eq("rd_pc", 64'(rt_o_rd_pc), 64'(m_last_pc));
      check_eq("rd_data", 64'(rt_o_rd_data), 64'(m_last_data));
      check_eq("drain_done", 64'(rt_o_done), 64'd1);
      check_eq("drain_ce", 64'(rt_o_ce), 64'd0);
      check_fifo_view();
    end
    rt_i_rd_en    = 1'b0;
    rt_i_wb_valid = 1'b0;
  endtask

  initial begin
    int n;
    rt_rst        = 1'b1;
    rt_i_start    = 1'b0;
    rt_i_cycles   = '0;
    rt_i_pc       = '0;
    rt_i_wb_data  = '0;
    rt_i_wb_valid = 1'b0;
    rt_i_rd_en    = 1'b0;
    m_ovf         = 1'b0;
    m_last_pc     = '0;
    m_last_data   = '0;
    step();
    check_reset();
    rt_rst = 1'b0;
    // rd_en in IDLE is ignored
    rt_i_rd_en = 1'b1;
    step();
    rt_i_rd_en = 1'b0;
    check_reset();

    // Directed: basic run, overflow run, zero-length run
    start_run(5, 1'b0);
    run_body(5, -1, 1'b0);
    drain();
    start_run(10, 1'b0);
    run_body(10, -1, 1'b1);
    drain();
    start_run(0, 1'b0);
    run_body(0, -1, 1'b0);
    drain();

    // Reset during the 3rd RUN cycle
    start_run(6, 1'b0);
    run_body(6, 2, 1'b0);

    // Start and rd_en together in DONE with 2 entries: start wins
    start_run(2, 1'b0);
    run_body(2, -1, 1'b1);
    start_run(3, 1'b1);
    run_body(3, -1, 1'b0);
    drain();

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      n = int'($urandom_range(0, 9));
      start_run(n, 1'($urandom_range(0, 1)));
      if (n >= 3 && $urandom_range(0, 4) == 0) begin
        run_body(n, 2, 1'b0);
      end else begin
        run_body(n, -1, 1'($urandom_range(0, 3) == 0));
        drain();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
